spi_cmd_monitor: RTL

SPI_CMD_MONITOR -- requirements
Module: spi_cmd_monitor

---
 rtl/spi_cmd_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_monitor.sv
// Passive SPI flash command monitor: opcode, address and byte count per transaction.
// Define SPI_MON_MISO_EN to also capture the last complete MISO byte.
`timescale 1ns/1ps
module spi_cmd_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_csb,
  input  logic             spi_mosi,
  input  logic             spi_miso,
  output logic             txn_done,
  output logic [7:0]       opcode,
  output logic [23:0]      addr,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             wr_flag,
  output logic             partial,
  output logic             sat
`ifdef SPI_MON_MISO_EN
  ,
  output logic [7:0]       miso_last
`endif
);

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, OPCODE, ADDR, DATA
  } state_t;

  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sck_prev_q, sck_prev_d;
  logic csb_prev_q, csb_prev_d;
  logic sck_s, csb_s, mosi_s;
  logic sck_rise, csb_rise, csb_fall;

  state_t           state_q;
  logic [2:0]       settle_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       mosi_sr_q;
  logic [7:0]       op_w_q;
  logic [23:0]      addr_w_q;
  logic [1:0]       addr_idx_q;
  logic [CNT_W-1:0] cnt_w_q;
  logic             sat_w_q;
  logic [7:0]       new_byte;
  logic             wr_op;

`ifdef SPI_MON_MISO_EN
  logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
  logic       miso_s;
  logic [6:0] miso_sr_q;

  // MISO synchronizer next-state
  always_comb begin
    miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], spi_miso};
  end

  // MISO synchronizer flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso_sync_q <= '0;
    else     miso_sync_q <= miso_sync_d;
  end

  assign miso_s = miso_sync_q[SYNC_STAGES-1];
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
`endif

  // Synchronizer and edge-history next-state
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    csb_prev_d  = csb_s;
  end

  // Synchronizer flops; csb idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      csb_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      csb_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      csb_prev_q  <= csb_prev_d;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;
  assign new_byte = {mosi_sr_q, mosi_s};
  assign wr_op    = op_w_q inside {8'h02, 8'h06, 8'h20, 8'hD8, 8'hC7};

  // Transaction FSM with working registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_IDLE;
      settle_q   <= '0;
      bit_cnt_q  <= '0;
      mosi_sr_q  <= '0;
      op_w_q     <= '0;
      addr_w_q   <= '0;
      addr_idx_q <= '0;
      cnt_w_q    <= '0;
      sat_w_q    <= 1'b0;
      txn_done   <= 1'b0;
      opcode     <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
      wr_flag    <= 1'b0;
      partial    <= 1'b0;
      sat        <= 1'b0;
`ifdef SPI_MON_MISO_EN
      miso_sr_q  <= '0;
      miso_last  <= '0;
`endif
    end else begin
      txn_done <= 1'b0;
      unique case (state_q)
        WAIT_IDLE: begin
          // wait until the synchronizers hold real csb samples
          if (settle_q != SETTLE) settle_q <= settle_q + 3'd1;
          else if (csb_s)         state_q  <= IDLE;
        end
        IDLE: begin
          if (csb_fall) begin
            bit_cnt_q  <= '0;
            mosi_sr_q  <= '0;
            op_w_q     <= '0;
            addr_w_q   <= '0;
            addr_idx_q <= '0;
            cnt_w_q    <= '0;
            sat_w_q    <= 1'b0;
`ifdef SPI_MON_MISO_EN
            miso_sr_q  <= '0;
`endif
            state_q    <= OPCODE;
          end
        end
        default: begin
          if (csb_rise) begin
            opcode   <= op_w_q;
            addr     <= addr_w_q;
            byte_cnt <= cnt_w_q;
            wr_flag  <= wr_op;
            partial  <= (bit_cnt_q != 3'd0);
            sat      <= sat_w_q;
            txn_done <= 1'b1;
            state_q  <= IDLE;
          end else if (sck_rise) begin
            mosi_sr_q <= new_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef SPI_MON_MISO_EN
            miso_sr_q <= {miso_sr_q[5:0], miso_s};
`endif
            if (bit_cnt_q == 3'd7) begin
              if (cnt_w_q == '1) sat_w_q <= 1'b1;
              else               cnt_w_q <= cnt_w_q + 1'b1;
`ifdef SPI_MON_MISO_EN
              miso_last <= {miso_sr_q, miso_s};
`endif
              if (state_q == OPCODE) begin
                op_w_q  <= new_byte;
                state_q <= ADDR;
              end else if (state_q == ADDR) begin
                if (addr_idx_q == 2'd0) addr_w_q[23:16] <= new_byte;
                if (addr_idx_q == 2'd1) addr_w_q[15:8]  <= new_byte;
                if (addr_idx_q == 2'd2) begin
                  addr_w_q[7:0] <= new_byte;
                  state_q       <= DATA;
                end
                addr_idx_q <= addr_idx_q + 2'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
